// File: rtl/orv64_ptw_cache_arb.sv
// Round-robin arbiter joining the ITLB/DTLB/VTLB walker cache ports onto one D-cache port.
// D-cache responses return in order and are steered back through an in-order source-ID FIFO.
package orv64_ptw_cache_pkg;
    localparam int ORV64_IPTW_SRC_ID = 0;
    localparam int ORV64_DPTW_SRC_ID = 1;
    localparam int ORV64_VPTW_SRC_ID = 2;

    typedef struct packed {
        logic [39:0] paddr;
        logic [3:0]  req_type;
        logic [7:0]  req_tid;
    } cpu_cache_if_req_t;

    typedef struct packed {
        logic [63:0] rd_data;
        logic [7:0]  resp_tid;
    } cpu_cache_if_resp_t;
endpackage

module orv64_ptw_cache_arb
    import orv64_ptw_cache_pkg::*;
#(
    parameter int N_OUTSTANDING = 4,
    parameter int N_PORTS       = 3
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [2:0]                        ptw_req_valid,
    input  cpu_cache_if_req_t [2:0]           ptw_req,
    output logic [2:0]                        ptw_req_ready,
    output logic [2:0]                        ptw_resp_valid,
    output cpu_cache_if_resp_t [2:0]          ptw_resp,
    input  logic [2:0]                        ptw_resp_ready,
    output logic                              dc_req_valid,
    output cpu_cache_if_req_t                 dc_req,
    input  logic                              dc_req_ready,
    input  logic                              dc_resp_valid,
    input  cpu_cache_if_resp_t                dc_resp,
    output logic                              dc_resp_ready,
    output logic [$clog2(N_OUTSTANDING):0]    outstanding_cnt,
    output logic                              err_unexpected_resp
);

    localparam int PTR_W = $clog2(N_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [1:0]       locked_id_q, locked_id_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [1:0]       fifo_q [N_OUTSTANDING];
    logic [1:0]       fifo_d [N_OUTSTANDING];

    logic [1:0] cand;
    logic [1:0] scan_idx;
    logic       found;
    logic [1:0] grant;
    logic [1:0] head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;

    assign full  = (count_q == CNT_W'(N_OUTSTANDING));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    // First valid walker starting at the round-robin pointer; an idle scan falls back to the pointer.
    always_comb begin
        cand     = rr_ptr_q;
        scan_idx = rr_ptr_q;
        found    = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!found && ptw_req_valid[scan_idx]) begin
                cand  = scan_idx;
                found = 1'b1;
            end
            scan_idx = next_port(scan_idx);
        end
    end

    assign grant = lock_q ? locked_id_q : cand;

    always_comb begin
        dc_req        = ptw_req[grant];
        dc_req_valid  = rstn && ptw_req_valid[grant] && !full;
        ptw_req_ready = 3'b000;
        if (rstn && dc_req_ready && !full) begin
            ptw_req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        ptw_resp_valid = 3'b000;
        for (int i = 0; i < N_PORTS; i++) begin
            ptw_resp[i] = dc_resp;
        end
        if (rstn && dc_resp_valid && !empty) begin
            ptw_resp_valid[head] = 1'b1;
        end
        dc_resp_ready = rstn && !empty && ptw_resp_ready[head];
    end

    assign push = dc_req_valid && dc_req_ready;
    assign pop  = dc_resp_valid && dc_resp_ready;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_d       = err_q;
        fifo_d      = fifo_q;

        // A stalled request pins the grant so the D-cache never sees the payload switch mid-request.
        if (push) begin
            lock_d           = 1'b0;
            rr_ptr_d         = next_port(grant);
            fifo_d[wr_ptr_q] = grant;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end else if (dc_req_valid && !dc_req_ready) begin
            lock_d      = 1'b1;
            locked_id_d = grant;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (dc_resp_valid && empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q    <= 2'd0;
            lock_q      <= 1'b0;
            locked_id_q <= 2'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    // Source-ID storage is only meaningful below count_q, so it carries no reset.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign outstanding_cnt     = count_q;
    assign err_unexpected_resp = err_q;

endmodule

// File: tb/tb_orv64_ptw_cache_arb.sv
// Directed bench for orv64_ptw_cache_arb: a queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_orv64_ptw_cache_arb;
    import orv64_ptw_cache_pkg::*;

    localparam int N_OUT = 4;

    logic                     clk;
    logic                     rstn;
    logic [2:0]               ptw_req_valid;
    cpu_cache_if_req_t [2:0]  ptw_req;
    logic [2:0]               ptw_req_ready;
    logic [2:0]               ptw_resp_valid;
    cpu_cache_if_resp_t [2:0] ptw_resp;
    logic [2:0]               ptw_resp_ready;
    logic                     dc_req_valid;
    cpu_cache_if_req_t        dc_req;
    logic                     dc_req_ready;
    logic                     dc_resp_valid;
    cpu_cache_if_resp_t       dc_resp;
    logic                     dc_resp_ready;
    logic [2:0]               outstanding_cnt;
    logic                     err_unexpected_resp;

    orv64_ptw_cache_arb #(.N_OUTSTANDING(N_OUT), .N_PORTS(3)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .ptw_req_valid      (ptw_req_valid),
        .ptw_req            (ptw_req),
        .ptw_req_ready      (ptw_req_ready),
        .ptw_resp_valid     (ptw_resp_valid),
        .ptw_resp           (ptw_resp),
        .ptw_resp_ready     (ptw_resp_ready),
        .dc_req_valid       (dc_req_valid),
        .dc_req             (dc_req),
        .dc_req_ready       (dc_req_ready),
        .dc_resp_valid      (dc_resp_valid),
        .dc_resp            (dc_resp),
        .dc_resp_ready      (dc_resp_ready),
        .outstanding_cnt    (outstanding_cnt),
        .err_unexpected_resp(err_unexpected_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: in-flight source IDs in issue order, rotation start, held grant.
    int q[$];
    int m_rr   = 0;
    bit m_lock = 1'b0;
    int m_lid  = 0;
    bit m_err  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  g;
        int  head;
        bit  full;
        bit  empty;
        bit  exp_dv;
        bit  exp_rr;
        bit  hs_req;
        bit  hs_resp;
        logic [2:0] exp_rdy;
        logic [2:0] exp_rv;
        if (!rstn) begin
            chk("rst_dc_req_valid", dc_req_valid, 0);
            chk("rst_ptw_req_ready", ptw_req_ready, 0);
            chk("rst_ptw_resp_valid", ptw_resp_valid, 0);
            chk("rst_dc_resp_ready", dc_resp_ready, 0);
            chk("rst_cnt", outstanding_cnt, 0);
            chk("rst_err", err_unexpected_resp, 0);
            q.delete();
            m_rr = 0; m_lock = 0; m_lid = 0; m_err = 0;
            return;
        end
        full  = (q.size() == N_OUT);
        empty = (q.size() == 0);
        g = m_rr;
        if (m_lock) g = m_lid;
        else begin
            for (int k = 2; k >= 0; k--)
                if (ptw_req_valid[(m_rr + k) % 3]) g = (m_rr + k) % 3;
        end
        exp_dv  = ptw_req_valid[g] && !full;
        exp_rdy = (dc_req_ready && !full) ? (3'b001 << g) : 3'b000;
        chk("m_dc_req_valid", dc_req_valid, exp_dv);
        chk("m_ptw_req_ready", ptw_req_ready, exp_rdy);
        if (exp_dv) chk("m_dc_req", dc_req, ptw_req[g]);
        head   = empty ? 0 : q[0];
        exp_rv = (dc_resp_valid && !empty) ? (3'b001 << head) : 3'b000;
        exp_rr = !empty && ptw_resp_ready[head];
        chk("m_ptw_resp_valid", ptw_resp_valid, exp_rv);
        chk("m_dc_resp_ready", dc_resp_ready, exp_rr);
        if (exp_rv != 0) chk("m_ptw_resp", ptw_resp[head], dc_resp);
        chk("m_cnt", outstanding_cnt, q.size());
        chk("m_err", err_unexpected_resp, m_err);

        hs_req  = exp_dv && dc_req_ready;
        hs_resp = dc_resp_valid && exp_rr;
        if (dc_resp_valid && empty) m_err = 1'b1;
        if (hs_resp) void'(q.pop_front());
        if (hs_req) begin
            q.push_back(g);
            m_rr   = (g + 1) % 3;
            m_lock = 1'b0;
        end else if (exp_dv) begin
            m_lock = 1'b1;
            m_lid  = g;
        end
    endtask

    // Inputs change at posedge+1; the model compares at the negedge and advances its state.
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn           = 1'b0;
        ptw_req_valid  = 3'b111;
        ptw_req[0]     = '{paddr: 40'h00_1000_0000, req_type: 4'h1, req_tid: 8'h10};
        ptw_req[1]     = '{paddr: 40'h00_2000_0040, req_type: 4'h2, req_tid: 8'h21};
        ptw_req[2]     = '{paddr: 40'h00_3000_0080, req_type: 4'h3, req_tid: 8'h32};
        ptw_resp_ready = 3'b111;
        dc_req_ready   = 1'b1;
        dc_resp_valid  = 1'b0;
        dc_resp        = '{rd_data: 64'hDEAD_BEEF_0000_0001, resp_tid: 8'h5A};
        #1;
        chk("reset_dc_req_valid", dc_req_valid, 1'b0);
        chk("reset_ptw_req_ready", ptw_req_ready, 3'b000);
        chk("reset_cnt", outstanding_cnt, 3'd0);
        cycle();
        cycle();
        rstn = 1'b1;
        ptw_req_valid = 3'b000;
        cycle();

        // Round-robin: all three walkers valid, grants rotate 0,1,2 twice.
        ptw_req_valid = 3'b111;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 3; p++) begin
                #1;
                chk("rr_grant", ptw_req_ready, 3'b001 << p);
                chk("rr_payload", dc_req, ptw_req[p]);
                cycle();
            end
            ptw_req_valid = 3'b000;
            dc_resp_valid = 1'b1;
            for (int p = 0; p < 3; p++) begin
                #1;
                chk("rr_resp_route", ptw_resp_valid, 3'b001 << p);
                cycle();
            end
            dc_resp_valid = 1'b0;
            ptw_req_valid = 3'b111;
        end
        ptw_req_valid = 3'b000;
        cycle();

        // Lock: D-cache stalls on port 0's request while port 2 also waits.
        ptw_req_valid = 3'b101;
        dc_req_ready  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("lock_valid", dc_req_valid, 1'b1);
            chk("lock_payload", dc_req, ptw_req[0]);
            cycle();
        end
        dc_req_ready = 1'b1;
        #1;
        chk("lock_accept", ptw_req_ready, 3'b001);
        cycle();
        ptw_req_valid = 3'b100;
        #1;
        chk("lock_next_grant", ptw_req_ready, 3'b100);
        cycle();
        ptw_req_valid = 3'b000;
        dc_resp_valid = 1'b1;
        #1;
        chk("lock_resp0", ptw_resp_valid, 3'b001);
        cycle();
        #1;
        chk("lock_resp2", ptw_resp_valid, 3'b100);
        cycle();
        dc_resp_valid = 1'b0;

        // Single request from port 1 with a one-cycle-later response.
        ptw_req_valid = 3'b010;
        #1;
        chk("single_dc_req", dc_req, ptw_req[1]);
        chk("single_ready", ptw_req_ready, 3'b010);
        cycle();
        ptw_req_valid = 3'b000;
        dc_resp_valid = 1'b1;
        #1;
        chk("single_cnt1", outstanding_cnt, 3'd1);
        chk("single_resp", ptw_resp_valid, 3'b010);
        chk("single_resp_ready", dc_resp_ready, 1'b1);
        cycle();
        dc_resp_valid = 1'b0;
        #1;
        chk("single_cnt0", outstanding_cnt, 3'd0);

        // Full: four accepted, fifth blocked until a pop lands.
        ptw_req_valid = 3'b001;
        for (int c = 0; c < 4; c++) cycle();
        #1;
        chk("full_cnt", outstanding_cnt, 3'd4);
        chk("full_ready", ptw_req_ready, 3'b000);
        chk("full_dc_valid", dc_req_valid, 1'b0);
        cycle();
        dc_resp_valid = 1'b1;
        #1;
        chk("full_pop_no_bypass", dc_req_valid, 1'b0);
        chk("full_pop_resp", ptw_resp_valid, 3'b001);
        cycle();
        dc_resp_valid = 1'b0;
        #1;
        chk("full_refill_ready", ptw_req_ready, 3'b001);
        cycle();
        ptw_req_valid = 3'b000;
        #1;
        chk("full_cnt_again", outstanding_cnt, 3'd4);
        dc_resp_valid = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        dc_resp_valid = 1'b0;
        #1;
        chk("full_drained", outstanding_cnt, 3'd0);

        // Ordering and backpressure: issue 2,0,1 then stall walker 2's response.
        ptw_req_valid = 3'b100; cycle();
        ptw_req_valid = 3'b001; cycle();
        ptw_req_valid = 3'b010; cycle();
        ptw_req_valid = 3'b000;
        ptw_resp_ready = 3'b011;
        dc_resp_valid  = 1'b1;
        #1;
        chk("order_stall_valid", ptw_resp_valid, 3'b100);
        chk("order_stall_ready", dc_resp_ready, 1'b0);
        cycle();
        cycle();
        #1;
        chk("order_stall_cnt", outstanding_cnt, 3'd3);
        ptw_resp_ready = 3'b111;
        #1;
        chk("order_first", ptw_resp_valid, 3'b100);
        cycle();
        ptw_req_valid = 3'b010;
        #1;
        chk("order_second", ptw_resp_valid, 3'b001);
        chk("order_cnt_before", outstanding_cnt, 3'd2);
        cycle();
        ptw_req_valid = 3'b000;
        #1;
        chk("order_cnt_after", outstanding_cnt, 3'd2);
        chk("order_third", ptw_resp_valid, 3'b010);
        cycle();
        #1;
        chk("order_fourth", ptw_resp_valid, 3'b010);
        cycle();
        dc_resp_valid = 1'b0;
        #1;
        chk("order_drained", outstanding_cnt, 3'd0);

        // Unexpected response with nothing outstanding.
        dc_resp_valid = 1'b1;
        #1;
        chk("err_resp_ready", dc_resp_ready, 1'b0);
        chk("err_resp_valid", ptw_resp_valid, 3'b000);
        chk("err_before", err_unexpected_resp, 1'b0);
        cycle();
        dc_resp_valid = 1'b0;
        #1;
        chk("err_set", err_unexpected_resp, 1'b1);
        cycle();
        cycle();
        #1;
        chk("err_sticky", err_unexpected_resp, 1'b1);
        rstn = 1'b0;
        #1;
        chk("err_cleared", err_unexpected_resp, 1'b0);
        cycle();
        rstn = 1'b1;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
